lcd_write_engine: RTL and testbench
===================================

# lcd_write_engine

Byte-level write sequencer for the HD44780-class character LCD. It sits between the LCD main controller and the LCD pins. On a one-cycle `lcd_enable` command it writes `lcd_cnt+1` bytes. For each byte it generates the RS/RW/DB setup, the E pulse, the hold window and the command-execution wait, then returns a one-cycle `lcd_finish`. Byte data comes from an upstream data mux, which the engine indexes through `data_idx`.

## Interface
Parameters:
- `T_SU`, 2: cycles RS/DB are stable before E rises (≥1)
- `T_PW`, 12: cycles E is high (≥1)
- `T_HOLD`, 2: cycles RS/DB are held after E falls (≥1)
- `T_WAIT_INIT`, 82000: post-byte execution wait in init mode (≥1)
- `T_WAIT_REF`, 2000: post-byte execution wait in refresh mode (≥1)
- `CNT_W`, 17: timing counter width; must hold max(all T_*)−1

Ports:
- `clk`, in, 1: system clock; all logic on rising edge
- `rst_n`, in, 1: asynchronous active-low reset
- `lcd_enable`, in, 1: start command, sampled only in IDLE
- `lcd_cnt`, in, 2: bytes to write minus 1 (0..3)
- `mode`, in, 1: 0 = LCD_INIT (long wait), 1 = LCD_REF (short wait)
- `reg_sel`, in, 1: RS value for the whole command
- `data_in`, in, 8: byte selected by `data_idx`, from the upstream mux
- `data_idx`, out, 2: index of the byte being requested
- `lcd_finish`, out, 1: one-cycle pulse when the command completes
- `busy`, out, 1: high from command acceptance until `lcd_finish`, inclusive
- `lcd_e`, out, 1: LCD enable strobe
- `lcd_rs`, out, 1: LCD register select
- `lcd_rw`, out, 1: tied 0 (write only)
- `lcd_db`, out, 8: LCD data bus

## Operation
- States: IDLE, SETUP, PULSE, HOLD, WAIT, DONE.
- IDLE:
  - `data_idx`=0 and `busy`=0.
  - If `lcd_enable`=1, latch `lcd_cnt`→`last`, `mode`, `reg_sel`→`lcd_rs`, and `data_in`→`lcd_db`.
  - Load the timing counter and go to SETUP.
- SETUP, T_SU cycles, `lcd_e`=0 → PULSE.
- PULSE, T_PW cycles, `lcd_e`=1 → HOLD.
- HOLD, T_HOLD cycles, `lcd_e`=0 → WAIT. On exit, if `data_idx`≠`last`, increment `data_idx`.
- WAIT, T_WAIT_INIT or T_WAIT_REF cycles (per latched `mode`):
  - If the byte just written was index `last`, go to DONE.
  - Otherwise latch `data_in`→`lcd_db` and go to SETUP.
- DONE, 1 cycle, `lcd_finish`=1 → IDLE.
- `lcd_rs` and `lcd_db` stay constant from SETUP through WAIT of each byte. They keep their last values in IDLE.
- `lcd_enable` is ignored outside IDLE. Input changes of `lcd_cnt`, `mode` and `reg_sel` mid-command have no effect.
- Timing counter counts down to 0. It is loaded with T_x−1 on state entry and never wraps.

## Timing
- Reset (async, `rst_n`=0): state IDLE, and every output drives 0 immediately (`lcd_e`, `lcd_rs`, `lcd_rw`, `lcd_db`, `data_idx`, `lcd_finish`, `busy`). This holds mid-command; E is cut immediately.
- Per-byte period: S = T_SU+T_PW+T_HOLD+T_WAIT cycles.
- Command accepted at edge k:
  - SETUP starts at edge k+1; `busy`=1 from k+1.
  - For n = `lcd_cnt`+1 bytes, `lcd_finish`=1 in the cycle after edge k+1+n·S.
  - `busy` drops one cycle later.
- Upstream must present `data_in` for `data_idx` within T_WAIT cycles of the `data_idx` change.
- A new `lcd_enable` in the first IDLE cycle after DONE is accepted (back-to-back).

## Test plan
All scenarios use T_SU=1, T_PW=2, T_HOLD=1, T_WAIT_REF=3, T_WAIT_INIT=5.

- Single refresh byte:
  - Stimulus: `lcd_enable` at edge k, `lcd_cnt`=0, `mode`=1, `reg_sel`=1, `data_in`=0x41.
  - Response: `lcd_db`=0x41 and `lcd_rs`=1 from k+1; `lcd_e` high exactly on cycles k+2..k+3; `lcd_finish` pulse at k+8; `busy` low at k+9.
- Four init bytes:
  - Stimulus: `lcd_cnt`=3, `mode`=0, `reg_sel`=0, mux returns 0x38, 0x0C, 0x06, 0x01 for idx 0..3.
  - Response: exactly four E pulses, 9 cycles apart; `lcd_db` in that order; `data_idx` steps 0→1→2→3; `lcd_finish` at k+37.
- Start while busy:
  - Stimulus: `lcd_enable` pulsed during PULSE of a 1-byte command.
  - Response: no extra E pulse; one `lcd_finish` only.
- Reset in PULSE:
  - Stimulus: `rst_n` low while `lcd_e`=1.
  - Response: `lcd_e`, `lcd_db`, `busy` = 0 in the same cycle; after release, no `lcd_finish` until a new `lcd_enable`.
- Back-to-back:
  - Stimulus: `lcd_enable` on the cycle after `lcd_finish`, with `lcd_cnt`=1.
  - Response: accepted; two E pulses; second `lcd_finish` 1+2·7 cycles later.
- Input change mid-command:
  - Stimulus: toggle `mode`, `reg_sel` and `lcd_cnt` during SETUP.
  - Response: `lcd_rs`, wait length and byte count follow the values latched at acceptance.

Source files
------------

// File: rtl/lcd_write_if.sv
// Controller-side command handshake plus LCD pin bundle for the byte write engine.
// The master modport is the LCD main controller / bench; the slave modport is the engine.
interface lcd_write_if;
  logic       lcd_enable;
  logic [1:0] lcd_cnt;
  logic       mode;
  logic       reg_sel;
  logic [7:0] data_in;
  logic [1:0] data_idx;
  logic       lcd_finish;
  logic       busy;
  logic       lcd_e;
  logic       lcd_rs;
  logic       lcd_rw;
  logic [7:0] lcd_db;

  modport master (
    output lcd_enable, lcd_cnt, mode, reg_sel, data_in,
    input  data_idx, lcd_finish, busy, lcd_e, lcd_rs, lcd_rw, lcd_db
  );

  modport slave (
    input  lcd_enable, lcd_cnt, mode, reg_sel, data_in,
    output data_idx, lcd_finish, busy, lcd_e, lcd_rs, lcd_rw, lcd_db
  );
endinterface

// File: rtl/lcd_write_engine.sv
// HD44780 byte write sequencer: per byte drives setup, E pulse, hold and the
// command-execution wait, then pulses lcd_finish once the whole command is done.
module lcd_write_engine #(
  parameter int T_SU        = 2,
  parameter int T_PW        = 12,
  parameter int T_HOLD      = 2,
  parameter int T_WAIT_INIT = 82000,
  parameter int T_WAIT_REF  = 2000,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  lcd_write_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT, S_DONE
  } state_t;

  localparam logic [CNT_W-1:0] SU_LD   = CNT_W'(T_SU - 1);
  localparam logic [CNT_W-1:0] PW_LD   = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] INIT_LD = CNT_W'(T_WAIT_INIT - 1);
  localparam logic [CNT_W-1:0] REF_LD  = CNT_W'(T_WAIT_REF - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_Z   = '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       last_q, last_d;
  logic             mode_q, mode_d;
  logic             last_byte_q, last_byte_d;
  logic [1:0]       idx_q, idx_d;
  logic             e_q, e_d;
  logic             rs_q, rs_d;
  logic [7:0]       db_q, db_d;
  logic             finish_q, finish_d;
  logic             busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    mode_d      = mode_q;
    last_byte_d = last_byte_q;
    idx_d       = idx_q;
    e_d         = e_q;
    rs_d        = rs_q;
    db_d        = db_q;
    finish_d    = 1'b0;
    busy_d      = busy_q;

    case (state_q)
      S_IDLE: begin
        if (bus.lcd_enable) begin
          last_d  = bus.lcd_cnt;
          mode_d  = bus.mode;
          rs_d    = bus.reg_sel;
          db_d    = bus.data_in;
          cnt_d   = SU_LD;
          busy_d  = 1'b1;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == CNT_Z) begin
          e_d     = 1'b1;
          cnt_d   = PW_LD;
          state_d = S_PULSE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_PULSE: begin
        if (cnt_q == CNT_Z) begin
          e_d     = 1'b0;
          cnt_d   = HOLD_LD;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_HOLD: begin
        if (cnt_q == CNT_Z) begin
          // Advance the index early so upstream has the whole wait to settle data_in.
          last_byte_d = (idx_q == last_q);
          if (idx_q != last_q) idx_d = idx_q + 2'd1;
          cnt_d   = mode_q ? REF_LD : INIT_LD;
          state_d = S_WAIT;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_Z) begin
          if (last_byte_q) begin
            finish_d = 1'b1;
            state_d  = S_DONE;
          end else begin
            db_d    = bus.data_in;
            cnt_d   = SU_LD;
            state_d = S_SETUP;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      S_DONE: begin
        idx_d   = 2'd0;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_q      <= 2'd0;
      mode_q      <= 1'b0;
      last_byte_q <= 1'b0;
      idx_q       <= 2'd0;
      e_q         <= 1'b0;
      rs_q        <= 1'b0;
      db_q        <= 8'd0;
      finish_q    <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      mode_q      <= mode_d;
      last_byte_q <= last_byte_d;
      idx_q       <= idx_d;
      e_q         <= e_d;
      rs_q        <= rs_d;
      db_q        <= db_d;
      finish_q    <= finish_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.data_idx   = idx_q;
  assign bus.lcd_finish = finish_q;
  assign bus.busy       = busy_q;
  assign bus.lcd_e      = e_q;
  assign bus.lcd_rs     = rs_q;
  assign bus.lcd_rw     = 1'b0;
  assign bus.lcd_db     = db_q;

endmodule

// File: tb/tb_lcd_write_engine.sv
// Directed bench for lcd_write_engine with short timing (SU=1, PW=2, HOLD=1, REF=3, INIT=5).
// Cycle c=0 is the SETUP cycle right after the edge that samples lcd_enable.
module tb_lcd_write_engine;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  int   e_rises = 0;
  int   fin_pulses = 0;
  logic e_prev = 1'b0;
  logic [7:0] tbl [4];

  always #5 clk = ~clk;

  lcd_write_if bus();

  lcd_write_engine #(
    .T_SU(1), .T_PW(2), .T_HOLD(1), .T_WAIT_INIT(5), .T_WAIT_REF(3), .CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  assign bus.data_in = tbl[bus.data_idx];

  always @(negedge clk) begin
    if (bus.lcd_e && !e_prev) e_rises++;
    e_prev = bus.lcd_e;
    if (bus.lcd_finish) fin_pulses++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_cmd(input logic [1:0] cnt, input logic m, input logic rs);
    bus.lcd_enable = 1'b1;
    bus.lcd_cnt    = cnt;
    bus.mode       = m;
    bus.reg_sel    = rs;
    step();
    bus.lcd_enable = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.lcd_enable = 1'b0;
    bus.lcd_cnt = 2'd0;
    bus.mode = 1'b0;
    bus.reg_sel = 1'b0;
    #12;
    checks++;
    if ({bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_finish, bus.busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=00000",
               {bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_finish, bus.busy});
    end
    checks++;
    if (bus.lcd_db !== 8'h00 || bus.data_idx !== 2'd0) begin
      failures++;
      $display("FAIL reset_bus db=%h idx=%0d exp db=00 idx=0", bus.lcd_db, bus.data_idx);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_ref();
    logic exp_e;
    tbl[0] = 8'h41;
    start_cmd(2'd0, 1'b1, 1'b1);
    for (int c = 0; c <= 8; c++) begin
      exp_e = (c == 1 || c == 2);
      checks++;
      if (bus.lcd_e !== exp_e) begin
        failures++;
        $display("FAIL single_e c=%0d got=%b exp=%b", c, bus.lcd_e, exp_e);
      end
      checks++;
      if (bus.lcd_finish !== (c == 7) || bus.busy !== (c < 8)) begin
        failures++;
        $display("FAIL single_fin_busy c=%0d fin=%b busy=%b exp fin=%b busy=%b",
                 c, bus.lcd_finish, bus.busy, (c == 7), (c < 8));
      end
      checks++;
      if (bus.lcd_db !== 8'h41 || bus.lcd_rs !== 1'b1 || bus.lcd_rw !== 1'b0) begin
        failures++;
        $display("FAIL single_bus c=%0d db=%h rs=%b rw=%b exp db=41 rs=1 rw=0",
                 c, bus.lcd_db, bus.lcd_rs, bus.lcd_rw);
      end
      step();
    end
  endtask

  task automatic test_four_init();
    int   rises0;
    logic exp_e;
    int   exp_idx;
    int   bsel;
    tbl[0] = 8'h38; tbl[1] = 8'h0C; tbl[2] = 8'h06; tbl[3] = 8'h01;
    rises0 = e_rises;
    start_cmd(2'd3, 1'b0, 1'b0);
    for (int c = 0; c <= 37; c++) begin
      exp_e   = (c < 36) && ((c % 9 == 1) || (c % 9 == 2));
      exp_idx = (c >= 37 || c < 4) ? 0 : (((c - 4) / 9 + 1) > 3 ? 3 : (c - 4) / 9 + 1);
      bsel    = (c / 9 > 3) ? 3 : c / 9;
      checks++;
      if (bus.lcd_e !== exp_e || bus.lcd_finish !== (c == 36)) begin
        failures++;
        $display("FAIL init_e_fin c=%0d e=%b fin=%b exp e=%b fin=%b",
                 c, bus.lcd_e, bus.lcd_finish, exp_e, (c == 36));
      end
      checks++;
      if (bus.data_idx !== 2'(exp_idx) || bus.lcd_db !== tbl[bsel] || bus.lcd_rs !== 1'b0) begin
        failures++;
        $display("FAIL init_bus c=%0d idx=%0d db=%h rs=%b exp idx=%0d db=%h rs=0",
                 c, bus.data_idx, bus.lcd_db, bus.lcd_rs, exp_idx, tbl[bsel]);
      end
      step();
    end
    checks++;
    if (e_rises - rises0 != 4) begin
      failures++;
      $display("FAIL init_pulse_count got=%0d exp=4", e_rises - rises0);
    end
  endtask

  task automatic test_start_while_busy();
    int rises0, fins0;
    tbl[0] = 8'h55;
    rises0 = e_rises;
    fins0  = fin_pulses;
    start_cmd(2'd0, 1'b1, 1'b0);
    for (int c = 0; c <= 12; c++) begin
      bus.lcd_enable = (c == 1);
      step();
    end
    bus.lcd_enable = 1'b0;
    checks++;
    if (e_rises - rises0 != 1 || fin_pulses - fins0 != 1) begin
      failures++;
      $display("FAIL busy_ignore rises=%0d fins=%0d exp rises=1 fins=1",
               e_rises - rises0, fin_pulses - fins0);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_ignore_idle busy=%b exp=0", bus.busy);
    end
  endtask

  task automatic test_reset_in_pulse();
    int rises0, fins0;
    tbl[0] = 8'h7E;
    start_cmd(2'd0, 1'b1, 1'b1);
    step();
    checks++;
    if (bus.lcd_e !== 1'b1) begin
      failures++;
      $display("FAIL rstp_pre e=%b exp=1", bus.lcd_e);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.lcd_e !== 1'b0 || bus.lcd_db !== 8'h00 || bus.busy !== 1'b0 || bus.lcd_rs !== 1'b0) begin
      failures++;
      $display("FAIL rstp_cut e=%b db=%h busy=%b rs=%b exp all 0",
               bus.lcd_e, bus.lcd_db, bus.busy, bus.lcd_rs);
    end
    @(negedge clk);
    rst_n = 1'b1;
    rises0 = e_rises;
    fins0  = fin_pulses;
    for (int c = 0; c < 12; c++) step();
    checks++;
    if (e_rises != rises0 || fin_pulses != fins0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rstp_quiet rises=%0d fins=%0d busy=%b exp 0 0 0",
               e_rises - rises0, fin_pulses - fins0, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    int rises0;
    tbl[0] = 8'h11; tbl[1] = 8'h22;
    start_cmd(2'd0, 1'b1, 1'b1);
    for (int c = 0; c < 7; c++) step();
    checks++;
    if (bus.lcd_finish !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first_fin got=%b exp=1", bus.lcd_finish);
    end
    step();
    checks++;
    if (bus.busy !== 1'b0 || bus.data_idx !== 2'd0) begin
      failures++;
      $display("FAIL b2b_idle busy=%b idx=%0d exp busy=0 idx=0", bus.busy, bus.data_idx);
    end
    rises0 = e_rises;
    start_cmd(2'd1, 1'b1, 1'b0);
    for (int d = 0; d <= 15; d++) begin
      checks++;
      if (bus.lcd_finish !== (d == 14) || bus.busy !== (d < 15)) begin
        failures++;
        $display("FAIL b2b_fin d=%0d fin=%b busy=%b exp fin=%b busy=%b",
                 d, bus.lcd_finish, bus.busy, (d == 14), (d < 15));
      end
      if (d == 7) begin
        checks++;
        if (bus.lcd_db !== 8'h22 || bus.lcd_rs !== 1'b0) begin
          failures++;
          $display("FAIL b2b_second_byte db=%h rs=%b exp db=22 rs=0", bus.lcd_db, bus.lcd_rs);
        end
      end
      step();
    end
    checks++;
    if (e_rises - rises0 != 2) begin
      failures++;
      $display("FAIL b2b_pulses got=%0d exp=2", e_rises - rises0);
    end
  endtask

  task automatic test_input_change();
    int rises0;
    int fin_at;
    tbl[0] = 8'h90; tbl[1] = 8'h91; tbl[2] = 8'hA2; tbl[3] = 8'hA3;
    rises0 = e_rises;
    fin_at = -1;
    start_cmd(2'd1, 1'b0, 1'b1);
    bus.mode    = 1'b1;
    bus.reg_sel = 1'b0;
    bus.lcd_cnt = 2'd3;
    for (int c = 0; c <= 24; c++) begin
      if (bus.lcd_finish === 1'b1 && fin_at < 0) fin_at = c;
      checks++;
      if (bus.lcd_rs !== 1'b1) begin
        failures++;
        $display("FAIL chg_rs c=%0d got=%b exp=1", c, bus.lcd_rs);
      end
      step();
    end
    checks++;
    if (fin_at != 18 || e_rises - rises0 != 2) begin
      failures++;
      $display("FAIL chg_len fin_at=%0d rises=%0d exp fin_at=18 rises=2",
               fin_at, e_rises - rises0);
    end
  endtask

  initial begin
    tbl[0] = 8'h00; tbl[1] = 8'h00; tbl[2] = 8'h00; tbl[3] = 8'h00;
    test_reset();
    test_single_ref();
    test_four_init();
    test_start_while_busy();
    test_reset_in_pulse();
    test_back_to_back();
    test_input_change();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
